// File: rtl/shift_reg_universal.sv
// ---------------------------------------------------------------------------
// shift_reg_universal
//
// Parametrised universal shift register with left/right shift, rotate,
// parallel load and clear, plus a counted burst engine that applies a
// shift/rotate a programmed number of times on its own.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (clears q and burst engine)
//   en           clock enable for direct ops and burst shifting
//   mode         000 hold, 001 shl, 010 shr, 011 rotl, 100 rotr,
//                101 load, 110 clear, 111 hold
//   sin_l        serial input entering bit 0 on shift-left
//   sin_r        serial input entering bit WIDTH-1 on shift-right
//   par_in       parallel load data
//   burst_start  start a burst with the current mode (shift/rotate only)
//   burst_len    number of shifts in the burst
//   q            register contents
//   sout_l       q[WIDTH-1]
//   sout_r       q[0]
//   busy         burst in progress
//   done         one-cycle burst-complete pulse
// ---------------------------------------------------------------------------
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] par_in,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROTL  = 3'b011;
    localparam logic [2:0] M_ROTR  = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       burst_mode;
    logic             start_ok;

    // Next register value for a given operation; shared by direct ops
    // and the burst engine so both behave identically.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] pin
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        case (op)
            M_SHL:   nxt = {cur[WIDTH-2:0], sl};
            M_SHR:   nxt = {sr, cur[WIDTH-1:1]};
            M_ROTL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROTR:  nxt = {cur[0], cur[WIDTH-1:1]};
            M_LOAD:  nxt = pin;
            M_CLEAR: nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Only shift/rotate modes can be run as a burst; anything else with
    // burst_start falls through to a normal direct op.
    assign start_ok = burst_start && (mode >= M_SHL) && (mode <= M_ROTR);

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            state      <= ST_IDLE;
            cnt        <= '0;
            burst_mode <= M_HOLD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        // The start edge only arms the engine; no shift here.
                        burst_mode <= mode;
                        cnt        <= burst_len;
                        state      <= (burst_len == CNT_ZERO) ? ST_DONE : ST_BUSY;
                    end else if (en) begin
                        q <= apply_op(mode, q, sin_l, sin_r, par_in);
                    end
                end
                ST_BUSY: begin
                    if (en) begin
                        q   <= apply_op(burst_mode, q, sin_l, sin_r, par_in);
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (en) begin
                        q <= apply_op(mode, q, sin_l, sin_r, par_in);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign busy   = (state == ST_BUSY);
    assign done   = (state == ST_DONE);

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised universal shift register. Successor to the team's fixed 4-bit serial-in/serial-out left shifter.
- Adds configurable width, left/right shift, rotate, parallel load/clear, and dual serial outputs.
- Adds a counted "burst" engine that shifts a programmed number of bits autonomously, with busy/done status.
- Used as the serializer/deserializer and bit-manipulation building block in the register library.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, $clog2(WIDTH+1)+1, burst counter width (derived; bursts up to 2^CNT_W-1 bits allowed)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  clock enable for direct ops and burst shifting
- mode  input  3  operation select (see Behaviour)
- sin_l  input  1  serial in at bit 0 for shift-left
- sin_r  input  1  serial in at bit WIDTH-1 for shift-right
- par_in  input  WIDTH  parallel load data
- burst_start  input  1  start a counted burst using current mode
- burst_len  input  CNT_W  number of shifts in the burst
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  burst in progress
- done  output  1  one-cycle burst-complete pulse

Behaviour:
- Reset (rst=1 at an edge), applies in every state including mid-burst:
  - q=0, FSM=IDLE, counter=0, busy=0, done=0.
- mode encoding:
  - 000 hold
  - 001 shift left: q <= {q[W-2:0], sin_l}
  - 010 shift right: q <= {sin_r, q[W-1:1]}
  - 011 rotate left
  - 100 rotate right
  - 101 load par_in
  - 110 clear to 0
  - 111 hold (reserved)
- Direct ops: in IDLE or DONE with en=1, the selected op is applied at the edge. en=0 holds q.
- Latency: q updates at the same edge the inputs are sampled. sout_l/sout_r add no register delay.
- FSM states:
  - IDLE: busy=0, done=0.
    - burst_start=1 with mode in 001..100 → BUSY. Latch mode into burst_mode and burst_len into counter. No shift on the start edge, regardless of en.
    - burst_start=1 with burst_len=0 → DONE directly, q unchanged.
    - burst_start=1 with mode not in 001..100 → start ignored; the op executes as a normal direct op.
    - burst_start takes priority over the direct op in the same cycle.
  - BUSY: busy=1.
    - Each edge with en=1: apply burst_mode and decrement the counter.
    - en=0: stall; q and counter hold.
    - Edge where counter==1 and en=1: final shift, → DONE.
    - mode, par_in and burst_start are ignored in BUSY.
  - DONE: busy=0, done=1 for exactly one cycle, then → IDLE.
    - Direct ops with en=1 are honoured in DONE.
    - burst_start is ignored in DONE.
- A burst of N with en held high:
  - busy is high for N cycles after the start edge.
  - done is high in cycle N+1.
- burst_len > WIDTH is legal. Rotates wrap modulo WIDTH; shifts keep filling from the serial input.
- Serial inputs are sampled live every shifting edge during a burst.

Test Plan:
- rst=1 for 2 edges with garbage inputs → q=0x00, busy=0, done=0, sout_l=sout_r=0.
- WIDTH=8, en=1, mode=001, sin_l stream 1,0,1,1,0,0,1,0 over 8 edges → q=0xB2. Then mode=010 with sin_r=0 for 1 edge → q=0x59, sout_r=1.
- Load 0x81 (mode=101), then mode=100 for 1 edge → q=0xC0. Then mode=011 for 2 edges → q=0x03. Then mode=110 → q=0x00.
- Load 0xA5; burst_start=1, mode=011, burst_len=3, en=1:
  - start edge: q stays 0xA5, busy=1.
  - next 3 edges: q = 0x4B, 0x96, 0x2D.
  - cycle after the 3rd shift: busy=0, done=1.
  - following cycle: done=0.
- Same burst with en=0 for 2 cycles after the first shift → q holds 0x4B and busy stays 1 during the stall. Completion is delayed exactly 2 cycles. Also: burst_len=0 → done pulses next cycle, q unchanged, busy never asserted.
- Reset mid-burst after 1 shift → next cycle q=0, busy=0, done=0, no done pulse. A new burst starts cleanly afterwards. Also: burst_start with mode=101 → treated as a plain load, busy stays 0.
